// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-memory load/store sequencer with lane steering, extension and fault trapping
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_len,
    input  logic        req_sign,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] A_BYTE = 2'd0;
    localparam logic [1:0] A_HALF = 2'd1;
    localparam logic [1:0] A_WORD = 2'd2;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    addr_lo;
    logic [1:0]    len_q;
    logic          sign_q;

    logic          bad_req;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [31:0]   lane_word;
    logic [31:0]   load_ext;

    always_comb begin
        bad_req    = (req_len == 2'b11)
                   || (req_len == A_HALF && req_addr[0])
                   || (req_len == A_WORD && req_addr[1:0] != 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
        case (req_len)
            A_BYTE: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            A_HALF: begin
                be_calc    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_calc = {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Halfword loads are always aligned here, so a byte-granular shift also selects the right half.
    always_comb begin
        lane_word = mem_rdata >> {addr_lo, 3'b000};
        case (len_q)
            A_BYTE:  load_ext = {{24{~sign_q & lane_word[7]}}, lane_word[7:0]};
            A_HALF:  load_ext = {{16{~sign_q & lane_word[15]}}, lane_word[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            addr_lo         <= 2'b00;
            len_q           <= 2'b00;
            sign_q          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            rdata           <= 32'h0;
            mem_address     <= 32'h0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 4'b0000;
            mem_wdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo <= req_addr[1:0];
                        len_q   <= req_len;
                        sign_q  <= req_sign;
                        busy    <= 1'b1;
                        if (bad_req) begin
                            state <= FAULT;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state           <= ACCESS;
                            count           <= '0;
                            mem_address     <= {req_addr[31:2], 2'b00};
                            mem_read        <= ~req_we;
                            mem_write       <= req_we;
                            mem_byte_enable <= be_calc;
                            mem_wdata       <= wdata_calc;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_resp) begin
                        state           <= DONE;
                        done            <= 1'b1;
                        err             <= 1'b0;
                        mem_read        <= 1'b0;
                        mem_write       <= 1'b0;
                        mem_byte_enable <= 4'b0000;
                        if (mem_read)
                            rdata <= load_ext;
                    end else if (TIMEOUT_CYCLES != 0 && count == LAST_COUNT) begin
                        state           <= FAULT;
                        done            <= 1'b1;
                        err             <= 1'b1;
                        mem_read        <= 1'b0;
                        mem_write       <= 1'b0;
                        mem_byte_enable <= 4'b0000;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with directed load/store/fault vectors
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_sign;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_len;
    logic        busy, done, err;
    logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [3:0]  mem_byte_enable;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] sb[$];
    logic [31:0] hold = 32'h0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_len(req_len), .req_sign(req_sign),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'h0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("done_err", {31'b0, err}, {31'b0, e[32]});
                chk("done_rdata", rdata, e[31:0]);
            end
        end
    end

    // Called at a negedge with the controller idle; returns at the negedge of the idle cycle after done.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] len, input logic sign, input int resp_at,
                          input logic [31:0] word, input int exp_cycles, input logic exp_err,
                          input logic [31:0] exp_rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
        int cnt;
        bit got;
        cnt = 0;
        got = 0;
        if (!exp_err && !we)
            hold = exp_rd;
        sb.push_back({exp_err, hold});
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_len = len; req_sign = sign;
        @(negedge clk);
        req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_len = 2'b11; req_sign = ~sign;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (i == 1)
                chk("busy_after_accept", {31'b0, busy}, 32'h1);
            if (mem_read || mem_write) begin
                cnt++;
                if (cnt == 1) begin
                    chk("mem_address", mem_address, {addr[31:2], 2'b00});
                    chk("byte_enable", {28'b0, mem_byte_enable}, {28'b0, exp_be});
                    chk("direction", {30'b0, mem_read, mem_write}, {30'b0, ~we, we});
                    if (we)
                        chk("mem_wdata", mem_wdata, exp_wd);
                end
                mem_resp = (cnt == resp_at);
                mem_rdata = word;
            end else begin
                mem_resp = 1'b0;
                mem_rdata = 32'h5A5A5A5A;
            end
            if (done) begin
                got = 1;
                req_valid = 1'b0;
                chk("done_latency", i, exp_cycles + 1);
            end
            @(negedge clk);
        end
        if (!got) begin
            req_valid = 1'b0;
            chk("done_timeout", 32'h0, 32'h1);
        end
        chk("access_cycles", cnt, exp_cycles);
        mem_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_len = 2'b00; req_sign = 1'b0; mem_resp = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {26'b0, busy, done, err, mem_read, mem_write, 1'b0}, 32'h0);
        chk("reset_be", {28'b0, mem_byte_enable}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_addr", mem_address, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        //     we    addr          wdata         len    sg  resp word          cyc err  exp_rd        be       wd
        do_req(1'b0, 32'h00000100, 32'h0,        2'd2,  1'b0, 3, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0);
        do_req(1'b0, 32'h00000103, 32'h0,        2'd0,  1'b0, 1, 32'h80FF0000, 1, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0);
        do_req(1'b0, 32'h00000103, 32'h0,        2'd0,  1'b1, 1, 32'h80FF0000, 1, 1'b0, 32'h00000080, 4'b1000, 32'h0);
        do_req(1'b0, 32'h00000102, 32'h0,        2'd1,  1'b0, 2, 32'h80FF0000, 2, 1'b0, 32'hFFFF80FF, 4'b1100, 32'h0);
        do_req(1'b0, 32'h00000100, 32'h0,        2'd1,  1'b1, 1, 32'h12348765, 1, 1'b0, 32'h00008765, 4'b0011, 32'h0);
        do_req(1'b0, 32'h00000101, 32'h0,        2'd0,  1'b0, 1, 32'h00007F00, 1, 1'b0, 32'h0000007F, 4'b0010, 32'h0);
        do_req(1'b1, 32'h00000202, 32'h0000ABCD, 2'd1,  1'b0, 2, 32'h0,        2, 1'b0, 32'h0,        4'b1100, 32'hABCD0000);
        do_req(1'b1, 32'h00000301, 32'h12345678, 2'd0,  1'b0, 1, 32'h0,        1, 1'b0, 32'h0,        4'b0010, 32'h00007800);
        do_req(1'b1, 32'h00000404, 32'hCAFEF00D, 2'd2,  1'b0, 1, 32'h0,        1, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D);
        do_req(1'b0, 32'h00000101, 32'h0,        2'd2,  1'b0, 0, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
        do_req(1'b0, 32'h00000100, 32'h0,        2'd3,  1'b0, 0, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
        do_req(1'b1, 32'h00000103, 32'h0,        2'd1,  1'b0, 0, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0);
        do_req(1'b0, 32'h00000600, 32'h0,        2'd2,  1'b0, 0, 32'h0,        4, 1'b1, 32'h0,        4'b1111, 32'h0);
        do_req(1'b0, 32'h00000604, 32'h0,        2'd2,  1'b0, 4, 32'h13572468, 4, 1'b0, 32'h13572468, 4'b1111, 32'h0);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00000500; req_len = 2'd2; req_sign = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("second_access_read", {31'b0, mem_read}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold = 32'h0;
        chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        mem_resp = 1'b1; mem_rdata = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            chk("late_resp_ctrl", {29'b0, busy, mem_read, done}, 32'h0);
            chk("late_resp_rdata", rdata, 32'h0);
        end
        mem_resp = 1'b0;
        do_req(1'b0, 32'h00000700, 32'h0,        2'd2,  1'b0, 1, 32'h0BADF00D, 1, 1'b0, 32'h0BADF00D, 4'b1111, 32'h0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
